// File: rtl/fft_sink_framer_if.sv
// Avalon-ST sink bus of the streaming FFT core: sample data, framing marks and
// the per-frame sideband that travels with every sample.
interface fft_sink_framer_if #(
  parameter int DATA_W       = 32,
  parameter int LOG2_MAX_PTS = 11
);
  logic [DATA_W-1:0]     fft_real;
  logic [DATA_W-1:0]     fft_imag;
  logic                  fft_valid;
  logic                  fft_ready;
  logic                  fft_sop;
  logic                  fft_eop;
  logic [1:0]            fft_error;
  logic                  fft_inverse;
  logic [LOG2_MAX_PTS:0] fft_pts;

  modport master (
    output fft_real, fft_imag, fft_valid, fft_sop, fft_eop, fft_error,
           fft_inverse, fft_pts,
    input  fft_ready
  );

  modport slave (
    input  fft_real, fft_imag, fft_valid, fft_sop, fft_eop, fft_error,
           fft_inverse, fft_pts,
    output fft_ready
  );
endinterface

// File: rtl/fft_sink_framer.sv
// Frames a continuous sample stream into fixed-length FFT sink packets; frames
// aborted upstream are zero-padded to full length.
module fft_sink_framer #(
  parameter int DATA_W       = 32,
  parameter int LOG2_MAX_PTS = 11,
  parameter int COMPLEX_IN   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        cfg_log2_pts,
  input  logic              cfg_inverse,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_valid,
  output logic              in_ready,
  fft_sink_framer_if.master sink,
  output logic              frame_done,
  output logic              pad_active,
  output logic              cfg_err
);
  localparam int IW = LOG2_MAX_PTS;
  localparam int PW = LOG2_MAX_PTS + 1;
  localparam logic [3:0]    MIN_L   = 4'd3;
  localparam logic [3:0]    MAX_L   = 4'(LOG2_MAX_PTS);
  localparam logic [PW-1:0] PTS_MAX = {1'b1, {IW{1'b0}}};
  localparam logic [PW-1:0] PTS_ONE = {{IW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]     idx;
  logic [PW-1:0]     pts_q;
  logic              inv_q;
  logic [DATA_W-1:0] imag_src;
  logic              load_en, accept, pad_ld, ld, latch, is_last, cfg_ok;
  logic [3:0]        log2_eff;
  logic [PW-1:0]     pts_new;

  generate
    if (COMPLEX_IN != 0) begin : g_cplx
      assign imag_src = in_imag;
    end else begin : g_real
      logic unused_imag;
      assign unused_imag = ^in_imag;
      assign imag_src    = '0;
    end
  endgenerate

  assign load_en  = !sink.fft_valid || sink.fft_ready;
  assign accept   = in_valid && in_ready;
  assign ld       = accept || pad_ld;
  assign is_last  = (idx == IW'(pts_q - PTS_ONE));
  assign cfg_ok   = (cfg_log2_pts >= MIN_L) && (cfg_log2_pts <= MAX_L);
  assign log2_eff = cfg_ok ? cfg_log2_pts : MAX_L;
  assign pts_new  = PTS_ONE << log2_eff;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = STREAM;
      STREAM: begin
        // an eop accepted together with a dropped enable closes the frame cleanly
        if (accept && is_last) begin
          if (!enable) state_nxt = IDLE;
        end else if (load_en && !enable) begin
          state_nxt = PAD;
        end
      end
      PAD:     if (pad_ld && is_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    pad_ld   = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE:    latch = enable;
      STREAM: begin
        in_ready = load_en;
        latch    = in_valid && load_en && is_last && enable;
      end
      PAD:     pad_ld = load_en;
      default: ;
    endcase
  end

  // Per-frame configuration, captured only at frame boundaries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pts_q   <= PTS_MAX;
      inv_q   <= 1'b0;
      cfg_err <= 1'b0;
    end else if (latch) begin
      pts_q <= pts_new;
      inv_q <= cfg_inverse;
      if (!cfg_ok) cfg_err <= 1'b1;
    end
  end

  // The largest frame wraps the index to zero naturally at eop
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   idx <= '0;
    else if (ld) idx <= is_last ? '0 : idx + 1'b1;
  end

  // Single output register; sideband rides with each sample so a relatch on
  // eop never relabels the eop sample itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sink.fft_valid   <= 1'b0;
      sink.fft_real    <= '0;
      sink.fft_imag    <= '0;
      sink.fft_sop     <= 1'b0;
      sink.fft_eop     <= 1'b0;
      sink.fft_inverse <= 1'b0;
      sink.fft_pts     <= PTS_MAX;
      pad_active       <= 1'b0;
    end else if (load_en) begin
      sink.fft_valid <= ld;
      sink.fft_sop   <= ld && (idx == '0);
      sink.fft_eop   <= ld && is_last;
      pad_active     <= pad_ld;
      if (ld) begin
        sink.fft_real    <= pad_ld ? '0 : in_real;
        sink.fft_imag    <= pad_ld ? '0 : imag_src;
        sink.fft_inverse <= inv_q;
        sink.fft_pts     <= pts_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= sink.fft_valid && sink.fft_ready && sink.fft_eop;
  end

  assign sink.fft_error = 2'b00;

endmodule

// File: tb/tb_fft_sink_framer.sv
// Self-checking bench for fft_sink_framer: directed sequence with random data
// and backpressure, checked against a frame-level reference model.
module tb_fft_sink_framer;
  localparam int DATA_W = 32;
  localparam int LMAX   = 11;
  localparam int CPLX   = 1;
  localparam int PW     = LMAX + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [3:0]        cfg_log2_pts = 4'd3;
  logic              cfg_inverse = 1'b0;
  logic [DATA_W-1:0] in_real = '0;
  logic [DATA_W-1:0] in_imag = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, frame_done, pad_active, cfg_err;

  fft_sink_framer_if #(.DATA_W(DATA_W), .LOG2_MAX_PTS(LMAX)) sink ();

  fft_sink_framer #(.DATA_W(DATA_W), .LOG2_MAX_PTS(LMAX), .COMPLEX_IN(CPLX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_log2_pts(cfg_log2_pts), .cfg_inverse(cfg_inverse),
    .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid), .in_ready(in_ready),
    .sink(sink),
    .frame_done(frame_done), .pad_active(pad_active), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              sop, eop, inv, pad;
    logic [PW-1:0]     pts;
    int                cyc;
  } xfer_t;

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } smp_t;

  // Core-side backpressure: 0 always ready, 1 pattern 1,0,0,1, 2 random
  int rdy_mode = 0;
  int rph = 0;
  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       begin sink.fft_ready = (rph == 0) || (rph == 3); rph = (rph + 1) % 4; end
      2:       sink.fft_ready = ($urandom_range(3) != 0);
      default: sink.fft_ready = 1'b1;
    endcase
  end

  // Monitor: records transfers and watches stall stability, frame_done timing
  // and the in_ready/load_en relation.
  xfer_t out_q[$];
  int    cyc = 0, fd_cnt = 0, fd_bad = 0, stall_chk = 0, stall_bad = 0;
  int    mir_chk = 0, mir_bad = 0;
  logic  prev_stall = 1'b0, prev_eopx = 1'b0;
  xfer_t prev;
  bit    mirror_en = 1'b0;

  always @(negedge clk) begin : mon
    xfer_t cur;
    cur.re = sink.fft_real;  cur.im  = sink.fft_imag;
    cur.sop = sink.fft_sop;  cur.eop = sink.fft_eop;
    cur.inv = sink.fft_inverse; cur.pad = pad_active;
    cur.pts = sink.fft_pts;  cur.cyc = cyc;
    cyc <= cyc + 1;
    if (prev_stall) begin
      stall_chk <= stall_chk + 1;
      if (!(sink.fft_valid === 1'b1 && cur.re === prev.re && cur.im === prev.im &&
            cur.sop === prev.sop && cur.eop === prev.eop))
        stall_bad <= stall_bad + 1;
    end
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (frame_done !== prev_eopx) fd_bad <= fd_bad + 1;
    if (mirror_en) begin
      mir_chk <= mir_chk + 1;
      if (in_ready !== (!sink.fft_valid || sink.fft_ready)) mir_bad <= mir_bad + 1;
    end
    if (sink.fft_valid === 1'b1 && sink.fft_ready === 1'b1) out_q.push_back(cur);
    prev_stall <= (sink.fft_valid === 1'b1) && (sink.fft_ready === 1'b0);
    prev_eopx  <= (sink.fft_valid === 1'b1) && (sink.fft_ready === 1'b1) && (sink.fft_eop === 1'b1);
    prev       <= cur;
  end

  int    n_pass = 0, n_chk = 0;
  smp_t  sent_q[$];
  int    sent_rd = 0;
  xfer_t exp_q[$];
  int    obase = 0, ebase = 0, fd0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic start_test();
    obase = out_q.size();
    ebase = exp_q.size();
    fd0   = fd_cnt;
  endtask

  // Reference model: one frame of pts samples, the first nreal taken from the
  // stimulus stream in order, the rest zero padding.
  task automatic add_frame(input int l2, input bit inv, input int nreal);
    int pts;
    pts = (l2 >= 3 && l2 <= LMAX) ? (1 << l2) : (1 << LMAX);
    for (int i = 0; i < pts; i++) begin
      xfer_t e;
      if (i < nreal) begin
        e.re = sent_q[sent_rd].re;
        e.im = (CPLX != 0) ? sent_q[sent_rd].im : '0;
        e.pad = 1'b0;
        sent_rd++;
      end else begin
        e.re = '0; e.im = '0; e.pad = 1'b1;
      end
      e.sop = (i == 0); e.eop = (i == pts - 1);
      e.inv = inv; e.pts = PW'(pts); e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int n, input bit drop_last, input bit gaps, input bit seq, input int seq_start);
    for (int i = 0; i < n; i++) begin
      smp_t s;
      bit   acc;
      int   w;
      s.re = seq ? DATA_W'(seq_start + i) : DATA_W'($urandom);
      s.im = DATA_W'($urandom);
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_real = s.re; in_imag = s.im; in_valid = 1'b1;
      if (drop_last && i == n - 1) enable = 1'b0;
      acc = 1'b0; w = 0;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = (in_ready === 1'b1);
        w++;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk("send_timeout", 64'd0, 64'd1);
        $fatal(1, "input never accepted");
      end
      sent_q.push_back(s);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n_exp, input bit nordy);
    int w = 0;
    while (out_q.size() < obase + n_exp && w < 8 * n_exp + 100) begin
      @(negedge clk);
      if (nordy) chk("pad_in_ready", 64'(in_ready), 64'd0);
      w++;
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(negedge clk);
      if (nordy) chk("pad_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("xfer_count", 64'(out_q.size() - obase), 64'(n_exp));
  endtask

  task automatic compare(input string tag);
    int n;
    n = exp_q.size() - ebase;
    for (int k = 0; k < n; k++) begin
      xfer_t a, e;
      if (obase + k >= out_q.size()) break;
      a = out_q[obase + k];
      e = exp_q[ebase + k];
      chk($sformatf("%s[%0d].real", tag, k), 64'(a.re),  64'(e.re));
      chk($sformatf("%s[%0d].imag", tag, k), 64'(a.im),  64'(e.im));
      chk($sformatf("%s[%0d].sop",  tag, k), 64'(a.sop), 64'(e.sop));
      chk($sformatf("%s[%0d].eop",  tag, k), 64'(a.eop), 64'(e.eop));
      chk($sformatf("%s[%0d].inv",  tag, k), 64'(a.inv), 64'(e.inv));
      chk($sformatf("%s[%0d].pts",  tag, k), 64'(a.pts), 64'(e.pts));
      chk($sformatf("%s[%0d].pad",  tag, k), 64'(a.pad), 64'(e.pad));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".valid"},  64'(sink.fft_valid),   64'd0);
    chk({tag, ".sop"},    64'(sink.fft_sop),     64'd0);
    chk({tag, ".eop"},    64'(sink.fft_eop),     64'd0);
    chk({tag, ".real"},   64'(sink.fft_real),    64'd0);
    chk({tag, ".imag"},   64'(sink.fft_imag),    64'd0);
    chk({tag, ".error"},  64'(sink.fft_error),   64'd0);
    chk({tag, ".inv"},    64'(sink.fft_inverse), 64'd0);
    chk({tag, ".pts"},    64'(sink.fft_pts),     64'd2048);
    chk({tag, ".fdone"},  64'(frame_done),       64'd0);
    chk({tag, ".pad"},    64'(pad_active),       64'd0);
    chk({tag, ".cfgerr"}, 64'(cfg_err),          64'd0);
    chk({tag, ".inrdy"},  64'(in_ready),         64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Two back-to-back 8-sample frames, data 1..16, continuous ready
    start_test();
    cfg_log2_pts = 4'd3; cfg_inverse = 1'b0; enable = 1'b1;
    send(16, 1'b1, 1'b0, 1'b1, 1);
    add_frame(3, 1'b0, 8);
    add_frame(3, 1'b0, 8);
    drain(16, 1'b0);
    compare("t1");
    for (int k = 1; k < 16 && obase + k < out_q.size(); k++)
      chk($sformatf("t1_gap[%0d]", k), 64'(out_q[obase + k].cyc - out_q[obase + k - 1].cyc), 64'd1);
    chk("t1_frame_done", 64'(fd_cnt - fd0), 64'd2);

    // Backpressure pattern 1,0,0,1 with in_ready mirroring load_en
    start_test();
    rdy_mode = 1; enable = 1'b1;
    @(posedge clk); #1;
    mirror_en = 1'b1;
    send(16, 1'b1, 1'b0, 1'b0, 0);
    mirror_en = 1'b0;
    add_frame(3, 1'b0, 8);
    add_frame(3, 1'b0, 8);
    drain(16, 1'b0);
    compare("t2");
    rdy_mode = 0;
    chk("t2_stalls_seen", 64'(stall_chk > 0), 64'd1);
    chk("t2_stall_stable", 64'(stall_bad), 64'd0);
    chk("t2_mirror_seen", 64'(mir_chk > 0), 64'd1);
    chk("t2_mirror", 64'(mir_bad), 64'd0);
    chk("t2_frame_done", 64'(fd_cnt - fd0), 64'd2);

    // Abort after 5 samples: 3 padded zeros, then idle
    start_test();
    enable = 1'b1;
    send(5, 1'b0, 1'b0, 1'b0, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    add_frame(3, 1'b0, 5);
    drain(8, 1'b1);
    compare("t3");
    repeat (10) @(posedge clk);
    #1;
    chk("t3_idle_no_xfer", 64'(out_q.size() - obase), 64'd8);
    chk("t3_frame_done", 64'(fd_cnt - fd0), 64'd1);

    // Abort before any sample: full zero frame with sop on the first zero
    start_test();
    cfg_inverse = 1'b1; enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b0;
    @(posedge clk); #1;
    add_frame(3, 1'b1, 0);
    drain(8, 1'b1);
    compare("t3b");

    // Config change mid-frame, random ready and input gaps
    start_test();
    rdy_mode = 2; cfg_log2_pts = 4'd3; cfg_inverse = 1'b0; enable = 1'b1;
    send(3, 1'b0, 1'b1, 1'b0, 0);
    cfg_log2_pts = 4'd4; cfg_inverse = 1'b1;
    send(21, 1'b1, 1'b1, 1'b0, 0);
    add_frame(3, 1'b0, 8);
    add_frame(4, 1'b1, 16);
    drain(24, 1'b0);
    compare("t4");
    rdy_mode = 0;
    chk("t4_cfg_err", 64'(cfg_err), 64'd0);

    // Out-of-range 12 clamps to 2048; index wraps into a back-to-back 8 frame
    start_test();
    cfg_log2_pts = 4'd12; cfg_inverse = 1'b0; enable = 1'b1;
    send(1, 1'b0, 1'b0, 1'b0, 0);
    cfg_log2_pts = 4'd3;
    send(2047 + 8, 1'b1, 1'b0, 1'b0, 0);
    add_frame(12, 1'b0, 2048);
    add_frame(3, 1'b0, 8);
    drain(2056, 1'b0);
    compare("t5");
    chk("t5_cfg_err", 64'(cfg_err), 64'd1);

    // Reset mid-frame while fft_valid is high
    cfg_log2_pts = 4'd3; enable = 1'b1;
    send(3, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_valid_before_reset", 64'(sink.fft_valid), 64'd1);
    reset = 1'b1;
    #1;
    check_reset("t6_async");
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sent_rd = sent_q.size();
    start_test();
    enable = 1'b1;
    send(8, 1'b1, 1'b0, 1'b0, 0);
    add_frame(3, 1'b0, 8);
    drain(8, 1'b0);
    compare("t6");

    // Below-range exponent also clamps and sets the sticky error
    start_test();
    cfg_log2_pts = 4'd2; enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b0;
    @(posedge clk); #1;
    chk("t7_cfg_err", 64'(cfg_err), 64'd1);
    add_frame(2, 1'b0, 0);
    drain(2048, 1'b1);
    compare("t7");

    chk("frame_done_align", 64'(fd_bad), 64'd0);
    chk("stall_stable_all", 64'(stall_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
